// File: rtl/conv_obuf_if.sv
// Beat/pixel bundle between the crossbar partial-sum source, conv_obuf and the next input buffer.
// The slave side is the buffer itself; the master side is whoever drives the beats.
`timescale 1ns/1ps
interface conv_obuf_if #(
    parameter int DATA_SIZE       = 8,
    parameter int ADC_WIDTH       = 8,
    parameter int OUTPUT_CHANNELS = 2,
    parameter int OUT_DATA_SIZE   = 8,
    parameter int COUNT_WIDTH     = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE)
) ();
    logic                       i_valid;
    logic                       o_ready;
    logic [COUNT_WIDTH-1:0]     i_count;
    logic [ADC_WIDTH-1:0]       i_data [OUTPUT_CHANNELS];
    logic [OUT_DATA_SIZE-1:0]   o_data [OUTPUT_CHANNELS];
    logic [OUTPUT_CHANNELS-1:0] o_write_enable;
    logic                       o_error;

    modport slave (
        input  i_valid, i_count, i_data,
        output o_ready, o_data, o_write_enable, o_error
    );

    modport master (
        output i_valid, i_count, i_data,
        input  o_ready, o_data, o_write_enable, o_error
    );
endinterface

// File: rtl/conv_obuf.sv
// Shift-accumulates bit-serial crossbar partial sums per channel, then scales, activates and emits one pixel.
// Optional feature macro CONV_OBUF_RELU_EN: ReLU with unsigned clamp; otherwise signed saturation.
`timescale 1ns/1ps
module conv_obuf #(
    parameter int DATA_SIZE       = 8,
    parameter int ADC_WIDTH       = 8,
    parameter int OUTPUT_CHANNELS = 2,
    parameter int OUT_DATA_SIZE   = 8,
    parameter int OUT_SHIFT       = 0,
    parameter int SIGNED_INPUT    = 1,
    parameter int COUNT_WIDTH     = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
    parameter int ACC_WIDTH       = ADC_WIDTH + DATA_SIZE + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    conv_obuf_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, ACTIVATE, EMIT} state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(DATA_SIZE - 1);

`ifdef CONV_OBUF_RELU_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((64'sd1 <<< OUT_DATA_SIZE) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = '0;
`else
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((64'sd1 <<< (OUT_DATA_SIZE - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(64'sd1 <<< (OUT_DATA_SIZE - 1)));
`endif

    state_t                   state, next_state;
    logic [COUNT_WIDTH-1:0]   exp_idx;
    logic signed [ACC_WIDTH-1:0] acc     [OUTPUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0] term    [OUTPUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0] scaled  [OUTPUT_CHANNELS];
    logic [OUT_DATA_SIZE-1:0]    sat_val [OUTPUT_CHANNELS];
    logic [OUT_DATA_SIZE-1:0]    data_q  [OUTPUT_CHANNELS];
    logic                     error_q;
    logic                     ready;
    logic                     accept;
    logic                     in_order;
    logic                     last_beat;
    logic                     first_beat;
    logic                     neg_beat;

    assign ready      = (state == IDLE) || (state == ACCUM);
    assign accept     = bus.i_valid && ready;
    assign in_order   = (bus.i_count == exp_idx);
    assign last_beat  = (bus.i_count == LAST_IDX);
    assign first_beat = (bus.i_count == '0);
    assign neg_beat   = (SIGNED_INPUT != 0) && last_beat;

    assign bus.o_ready        = ready;
    assign bus.o_error        = error_q;
    assign bus.o_data         = data_q;
    assign bus.o_write_enable = (state == EMIT) ? {OUTPUT_CHANNELS{1'b1}} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (!in_order)     next_state = IDLE;
                    else if (last_beat) next_state = ACTIVATE;
                    else               next_state = ACCUM;
                end
            end
            ACTIVATE: next_state = EMIT;
            EMIT:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Per-channel weighted beat, scaled accumulator and clamped output value.
    always_comb begin
        for (int c = 0; c < OUTPUT_CHANNELS; c++) begin
            term[c]    = ACC_WIDTH'(bus.i_data[c]) << bus.i_count;
            scaled[c]  = acc[c] >>> OUT_SHIFT;
            sat_val[c] = (scaled[c] > SAT_HI) ? SAT_HI[OUT_DATA_SIZE-1:0] :
                         (scaled[c] < SAT_LO) ? SAT_LO[OUT_DATA_SIZE-1:0] :
                                                scaled[c][OUT_DATA_SIZE-1:0];
        end
    end

    // An out-of-order beat throws away the partial pixel so the next index-0 beat restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_idx <= '0;
            error_q <= 1'b0;
            for (int c = 0; c < OUTPUT_CHANNELS; c++) begin
                acc[c]    <= '0;
                data_q[c] <= '0;
            end
        end else begin
            if (accept) begin
                if (in_order) begin
                    for (int c = 0; c < OUTPUT_CHANNELS; c++) begin
                        if (first_beat)    acc[c] <= neg_beat ? -term[c] : term[c];
                        else if (neg_beat) acc[c] <= acc[c] - term[c];
                        else               acc[c] <= acc[c] + term[c];
                    end
                    exp_idx <= last_beat ? '0 : exp_idx + COUNT_WIDTH'(1);
                end else begin
                    error_q <= 1'b1;
                    exp_idx <= '0;
                    for (int c = 0; c < OUTPUT_CHANNELS; c++) acc[c] <= '0;
                end
            end
            if (state == ACTIVATE) begin
                for (int c = 0; c < OUTPUT_CHANNELS; c++) data_q[c] <= sat_val[c];
            end
        end
    end

endmodule

// File: tb/tb_conv_obuf.sv
// Directed bench for conv_obuf: two instances (OUT_SHIFT 0 and 4) driven by the same beats.
// Expected pixels are hand-computed for both CONV_OBUF_RELU_EN builds.
`timescale 1ns/1ps
module tb_conv_obuf;
    localparam int DS = 4;
    localparam int AW = 8;
    localparam int CH = 2;
    localparam int OW = 8;
    localparam int CW = 2;

`ifdef CONV_OBUF_RELU_EN
    localparam logic [7:0] NEG1  = 8'h00;
    localparam logic [7:0] NEG8  = 8'h00;
    localparam logic [7:0] E1785 = 8'd255;
`else
    localparam logic [7:0] NEG1  = 8'hFF;
    localparam logic [7:0] NEG8  = 8'hF8;
    localparam logic [7:0] E1785 = 8'd127;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic [CW-1:0] count = '0;
    logic [AW-1:0] d0 = '0;
    logic [AW-1:0] d1 = '0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    int strobes = 0;
    int last_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_obuf_if #(.DATA_SIZE(DS), .ADC_WIDTH(AW), .OUTPUT_CHANNELS(CH), .OUT_DATA_SIZE(OW)) bus ();
    conv_obuf_if #(.DATA_SIZE(DS), .ADC_WIDTH(AW), .OUTPUT_CHANNELS(CH), .OUT_DATA_SIZE(OW)) bus_s ();

    assign bus.i_valid     = valid;
    assign bus.i_count     = count;
    assign bus.i_data[0]   = d0;
    assign bus.i_data[1]   = d1;
    assign bus_s.i_valid   = valid;
    assign bus_s.i_count   = count;
    assign bus_s.i_data[0] = d0;
    assign bus_s.i_data[1] = d1;

    conv_obuf #(.DATA_SIZE(DS), .ADC_WIDTH(AW), .OUTPUT_CHANNELS(CH), .OUT_DATA_SIZE(OW),
                .OUT_SHIFT(0), .SIGNED_INPUT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    conv_obuf #(.DATA_SIZE(DS), .ADC_WIDTH(AW), .OUTPUT_CHANNELS(CH), .OUT_DATA_SIZE(OW),
                .OUT_SHIFT(4), .SIGNED_INPUT(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int idx, input logic [7:0] a, input logic [7:0] b);
        valid = 1'b1;
        count = CW'(idx);
        d0 = a;
        d1 = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic pixel(input string tag,
                         input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] s0, input logic [7:0] s1);
        beat(0, a0, b0);
        beat(1, a1, b1);
        beat(2, a2, b2);
        beat(3, a3, b3);
        check({tag, "_act_we"}, bus.o_write_enable, 0);
        check({tag, "_act_ready"}, bus.o_ready, 0);
        @(posedge clk);
        #1;
        check({tag, "_emit_we"}, bus.o_write_enable, 2'b11);
        check({tag, "_d0"}, bus.o_data[0], e0);
        check({tag, "_d1"}, bus.o_data[1], e1);
        check({tag, "_shift_d0"}, bus_s.o_data[0], s0);
        check({tag, "_shift_d1"}, bus_s.o_data[1], s1);
        @(posedge clk);
        #1;
        check({tag, "_idle_we"}, bus.o_write_enable, 0);
        check({tag, "_idle_ready"}, bus.o_ready, 1);
        check({tag, "_hold_d0"}, bus.o_data[0], e0);
    endtask

    // Back-to-back pixel p carries ch0 = p+1 and ch1 = 2p, so each strobe identifies its pixel.
    always @(negedge clk) begin
        if (mon_en && bus.o_write_enable == 2'b11) begin
            check("b2b_d0", bus.o_data[0], strobes + 1);
            check("b2b_d1", bus.o_data[1], 2 * strobes);
            if (strobes > 0) check("b2b_gap", cyc - last_cyc, 6);
            last_cyc = cyc;
            strobes++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        #12;
        check("rst_ready", bus.o_ready, 1);
        check("rst_we", bus.o_write_enable, 0);
        check("rst_error", bus.o_error, 0);
        check("rst_d0", bus.o_data[0], 0);
        check("rst_d1", bus.o_data[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pixel("basic", 8'd1, 8'd1, 8'd1, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd7, 8'd2, 8'd0, 8'd0);
        pixel("minus1", 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, NEG1, 8'd0, NEG1, 8'd0);
        pixel("sat", 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, E1785, NEG8, 8'd111, NEG1);

        beat(0, 8'd5, 8'd5);
        check("order_error_pre", bus.o_error, 0);
        beat(2, 8'd5, 8'd5);
        check("order_error", bus.o_error, 1);
        check("order_we", bus.o_write_enable, 0);
        check("order_ready", bus.o_ready, 1);
        @(posedge clk);
        #1;
        check("order_we_later", bus.o_write_enable, 0);
        pixel("recover", 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd3, 8'd2, 8'd0, 8'd0);
        check("recover_error_sticky", bus.o_error, 1);

        stalls = 0;
        mon_en = 1'b1;
        valid = 1'b1;
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 4; i++) begin
                logic got;
                int w;
                count = CW'(i);
                d0 = (i == 0) ? 8'(p + 1) : 8'd0;
                d1 = (i == 1) ? 8'(p) : 8'd0;
                got = 1'b0;
                w = 0;
                while (!got && w < 20) begin
                    got = bus.o_ready;
                    if (!got) stalls++;
                    @(posedge clk);
                    #1;
                    w++;
                end
                check("b2b_accept", got, 1);
            end
        end
        valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("b2b_strobes", strobes, 10);
        check("b2b_stalls", stalls, 18);
        check("b2b_error_sticky", bus.o_error, 1);

        beat(0, 8'd9, 8'd4);
        beat(1, 8'd9, 8'd4);
        beat(2, 8'd9, 8'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", bus.o_ready, 1);
        check("arst_d0", bus.o_data[0], 0);
        check("arst_error", bus.o_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        beat(0, 8'd1, 8'd2);
        beat(1, 8'd1, 8'd0);
        beat(2, 8'd1, 8'd0);
        beat(3, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        check("emit_rst_we_before", bus.o_write_enable, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("emit_rst_we", bus.o_write_enable, 0);
        check("emit_rst_d0", bus.o_data[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pixel("fresh", 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0);
        check("fresh_error", bus.o_error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
